rgb_pwm_mmio: RTL and testbench

- Memory-mapped RGB LED PWM peripheral on the processor store bus (MemWrite/DataAdr/WriteData), directly downstream of the core top.
- Decodes word stores in its address window into control and duty registers.
- Generates three glitch-free active-low PWM outputs with optional frame-based blinking.
- Provides combinational read-back so single-cycle loads complete in the same cycle.

---
 rtl/rgb_pwm_mmio.sv | 219 +++++++++++++++++++++
 tb/tb_rgb_pwm_mmio.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_mmio.sv
// rgb_pwm_mmio: memory-mapped three-channel active-low PWM LED driver.
// Word stores inside the 32-byte window update control/duty registers;
// loads are answered combinationally. Each frame is 256 phases long; a
// phase advances once per prescaler tick. Duties are double-buffered so a
// frame never changes shape halfway through. Optional blinking forces the
// outputs off on alternate groups of BLINK_FRAMES frames.
module rgb_pwm_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
  parameter logic [15:0] PRESCALE_RST = 16'd46
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        hit,
  output logic        led_r_n,
  output logic        led_g_n,
  output logic        led_b_n
);

  // Register indices (word offset within the window)
  localparam logic [2:0] IDX_CTRL   = 3'd0;
  localparam logic [2:0] IDX_DUTY_R = 3'd1;
  localparam logic [2:0] IDX_DUTY_G = 3'd2;
  localparam logic [2:0] IDX_DUTY_B = 3'd3;
  localparam logic [2:0] IDX_PRESC  = 3'd4;
  localparam logic [2:0] IDX_BLINK  = 3'd5;
  localparam logic [2:0] IDX_STATUS = 3'd6;

  // Software-visible registers
  logic [1:0]  ctrl_q, ctrl_d;
  logic [7:0]  duty_r_q, duty_r_d;
  logic [7:0]  duty_g_q, duty_g_d;
  logic [7:0]  duty_b_q, duty_b_d;
  logic [15:0] prescale_q, prescale_d;
  logic [15:0] blink_frames_q, blink_frames_d;

  // Timebase and PWM state
  logic [15:0] presc_cnt_q, presc_cnt_d;
  logic [7:0]  phase_q, phase_d;
  logic [7:0]  shadow_r_q, shadow_r_d;
  logic [7:0]  shadow_g_q, shadow_g_d;
  logic [7:0]  shadow_b_q, shadow_b_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        blink_phase_q, blink_phase_d;
  logic        led_r_n_q, led_r_n_d;
  logic        led_g_n_q, led_g_n_d;
  logic        led_b_n_q, led_b_n_d;

  // Decode helpers
  logic [31:0] offset;
  logic [2:0]  idx;
  logic        wr_en;
  logic        enable;
  logic        blink_en;
  logic        tick;
  logic        frame_end;
  logic        shadow_load;
  logic        blank;
  logic        unused_bits;

  assign offset      = DataAdr - BASE_ADDR;
  assign idx         = offset[4:2];
  assign enable      = ctrl_q[0];
  assign blink_en    = ctrl_q[1];
  assign unused_bits = ^{offset[31:5], WriteData[31:16]};

  // Address window decode: inside the 32-byte window and word aligned
  always_comb begin
    hit = (DataAdr >= BASE_ADDR) && (DataAdr < (BASE_ADDR + 32'd32)) &&
          (DataAdr[1:0] == 2'b00);
  end

  assign wr_en = MemWrite && hit;

  // Combinational read-back of the software registers and status
  always_comb begin
    ReadData = 32'd0;
    if (hit) begin
      case (idx)
        IDX_CTRL:   ReadData = {30'd0, ctrl_q};
        IDX_DUTY_R: ReadData = {24'd0, duty_r_q};
        IDX_DUTY_G: ReadData = {24'd0, duty_g_q};
        IDX_DUTY_B: ReadData = {24'd0, duty_b_q};
        IDX_PRESC:  ReadData = {16'd0, prescale_q};
        IDX_BLINK:  ReadData = {16'd0, blink_frames_q};
        IDX_STATUS: ReadData = {15'd0, blink_phase_q, frame_cnt_q};
        default:    ReadData = 32'd0;
      endcase
    end
  end

  // Register write decode; STATUS and the reserved slot are not writable
  always_comb begin
    ctrl_d         = ctrl_q;
    duty_r_d       = duty_r_q;
    duty_g_d       = duty_g_q;
    duty_b_d       = duty_b_q;
    prescale_d     = prescale_q;
    blink_frames_d = blink_frames_q;
    if (wr_en) begin
      case (idx)
        IDX_CTRL:   ctrl_d         = WriteData[1:0];
        IDX_DUTY_R: duty_r_d       = WriteData[7:0];
        IDX_DUTY_G: duty_g_d       = WriteData[7:0];
        IDX_DUTY_B: duty_b_d       = WriteData[7:0];
        IDX_PRESC:  prescale_d     = WriteData[15:0];
        IDX_BLINK:  blink_frames_d = WriteData[15:0];
        default:    ;
      endcase
    end
  end

  // Prescaler and phase counter; both parked at zero while disabled.
  // A freshly loaded PRESCALE value is only picked up on the next reload.
  always_comb begin
    tick        = enable && (presc_cnt_q == 16'd0);
    frame_end   = tick && (phase_q == 8'hFF);
    presc_cnt_d = presc_cnt_q;
    phase_d     = phase_q;
    if (!enable) begin
      presc_cnt_d = 16'd0;
      phase_d     = 8'd0;
    end else if (tick) begin
      presc_cnt_d = prescale_q;
      phase_d     = phase_q + 8'd1;
    end else begin
      presc_cnt_d = presc_cnt_q - 16'd1;
    end
  end

  // Shadow duties: reloaded at each frame boundary and on enable rising.
  // Loading from the _d values lets a store on that same edge be captured.
  always_comb begin
    shadow_load = frame_end || (ctrl_d[0] && !ctrl_q[0]);
    shadow_r_d  = shadow_r_q;
    shadow_g_d  = shadow_g_q;
    shadow_b_d  = shadow_b_q;
    if (shadow_load) begin
      shadow_r_d = duty_r_d;
      shadow_g_d = duty_g_d;
      shadow_b_d = duty_b_d;
    end
  end

  // Blink frame counter; BLINK_FRAMES == 0 keeps blink_phase frozen
  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (!blink_en) begin
      frame_cnt_d   = 16'd0;
      blink_phase_d = 1'b0;
    end else if (!enable) begin
      frame_cnt_d = 16'd0;
    end else if (frame_end) begin
      if ((blink_frames_q != 16'd0) &&
          (frame_cnt_q == (blink_frames_q - 16'd1))) begin
        frame_cnt_d   = 16'd0;
        blink_phase_d = !blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
    end
  end

  // Output compare: on while shadow duty exceeds phase, unless blanked
  always_comb begin
    blank     = !enable || (blink_en && blink_phase_q);
    led_r_n_d = !(!blank && (shadow_r_q > phase_q));
    led_g_n_d = !(!blank && (shadow_g_q > phase_q));
    led_b_n_d = !(!blank && (shadow_b_q > phase_q));
  end

  // State registers; reset forces LEDs off immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q         <= 2'd0;
      duty_r_q       <= 8'd0;
      duty_g_q       <= 8'd0;
      duty_b_q       <= 8'd0;
      prescale_q     <= PRESCALE_RST;
      blink_frames_q <= 16'd0;
      presc_cnt_q    <= 16'd0;
      phase_q        <= 8'd0;
      shadow_r_q     <= 8'd0;
      shadow_g_q     <= 8'd0;
      shadow_b_q     <= 8'd0;
      frame_cnt_q    <= 16'd0;
      blink_phase_q  <= 1'b0;
      led_r_n_q      <= 1'b1;
      led_g_n_q      <= 1'b1;
      led_b_n_q      <= 1'b1;
    end else begin
      ctrl_q         <= ctrl_d;
      duty_r_q       <= duty_r_d;
      duty_g_q       <= duty_g_d;
      duty_b_q       <= duty_b_d;
      prescale_q     <= prescale_d;
      blink_frames_q <= blink_frames_d;
      presc_cnt_q    <= presc_cnt_d;
      phase_q        <= phase_d;
      shadow_r_q     <= shadow_r_d;
      shadow_g_q     <= shadow_g_d;
      shadow_b_q     <= shadow_b_d;
      frame_cnt_q    <= frame_cnt_d;
      blink_phase_q  <= blink_phase_d;
      led_r_n_q      <= led_r_n_d;
      led_g_n_q      <= led_g_n_d;
      led_b_n_q      <= led_b_n_d;
    end
  end

  assign led_r_n = led_r_n_q;
  assign led_g_n = led_g_n_q;
  assign led_b_n = led_b_n_q;

endmodule

// File: tb/tb_rgb_pwm_mmio.sv
// tb_rgb_pwm_mmio: directed bench for the RGB PWM peripheral.
module tb_rgb_pwm_mmio;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        hit;
  logic        led_r_n;
  logic        led_g_n;
  logic        led_b_n;

  int total;
  int bad;

  rgb_pwm_mmio dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .hit       (hit),
    .led_r_n   (led_r_n),
    .led_g_n   (led_g_n),
    .led_b_n   (led_b_n)
  );

  // Clock: 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    MemWrite  = 1'b1;
    DataAdr   = addr;
    WriteData = data;
    @(negedge clk);
    MemWrite  = 1'b0;
    WriteData = 32'd0;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    DataAdr = addr;
    #1;
    data = ReadData;
  endtask

  initial begin
    logic [31:0] v;
    int lo_r, lo_g, lo_b;
    int run, lows, guard;
    logic prev;

    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    MemWrite  = 1'b0;
    DataAdr   = 32'd0;
    WriteData = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_led_r", {31'd0, led_r_n}, 32'd1);
    chk("rst_led_g", {31'd0, led_g_n}, 32'd1);
    chk("rst_led_b", {31'd0, led_b_n}, 32'd1);
    rd(32'h404, v); chk("rst_duty_r", v, 32'd0);
    rd(32'h410, v); chk("rst_prescale", v, 32'd46);
    rd(32'h418, v); chk("rst_status", v, 32'd0);
    rd(32'h400, v); chk("rst_ctrl", v, 32'd0);
    rd(32'h41C, v); chk("rsvd_read", v, 32'd0);
    DataAdr = 32'h3FC; #1; chk("hit_below", {31'd0, hit}, 32'd0);
    DataAdr = 32'h420; #1; chk("hit_above", {31'd0, hit}, 32'd0);
    DataAdr = 32'h41C; #1; chk("hit_top", {31'd0, hit}, 32'd1);

    // Basic PWM: PRESCALE=0 gives a 256-clock frame
    store(32'h410, 32'hFFFF_0000);
    store(32'h404, 32'h0000_0140);  // upper bits dropped -> 0x40
    store(32'h408, 32'd0);
    store(32'h40C, 32'd255);
    rd(32'h410, v); chk("wr_prescale", v, 32'd0);
    rd(32'h404, v); chk("wr_duty_r_trunc", v, 32'h40);
    store(32'h400, 32'd1);
    repeat (5) @(negedge clk);
    lo_r = 0; lo_g = 0; lo_b = 0;
    for (int i = 0; i < 256; i++) begin
      if (!led_r_n) lo_r++;
      if (!led_g_n) lo_g++;
      if (!led_b_n) lo_b++;
      @(negedge clk);
    end
    chk("frame_r_low", lo_r, 32'd64);
    chk("frame_g_low", lo_g, 32'd0);
    chk("frame_b_low", lo_b, 32'd255);

    // Mid-frame duty change: wait for red to turn off (phase 64)
    prev  = led_r_n;
    guard = 0;
    while (!(prev == 1'b0 && led_r_n == 1'b1) && guard < 600) begin
      prev = led_r_n;
      @(negedge clk);
      guard++;
    end
    chk("wait_red_off", {31'd0, (guard < 600)}, 32'd1);
    run = 1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (i == 35) begin
        MemWrite  = 1'b1;
        DataAdr   = 32'h404;
        WriteData = 32'd200;
      end else if (i == 36) begin
        MemWrite  = 1'b0;
      end
      if (led_r_n) run++;
      else break;
    end
    MemWrite = 1'b0;
    chk("mid_frame_off_run", run, 32'd192);
    run = 0;
    for (int i = 0; i < 600; i++) begin
      if (!led_r_n) run++;
      else break;
      @(negedge clk);
    end
    chk("next_frame_on_run", run, 32'd200);

    // Blink: two frames active, two frames forced off
    store(32'h400, 32'd0);
    store(32'h414, 32'd2);
    store(32'h400, 32'd3);
    DataAdr = 32'h418;
    guard = 0;
    #1;
    while (ReadData[16] !== 1'b1 && guard < 3000) begin
      @(negedge clk); #1;
      guard++;
    end
    chk("wait_blink_on", {31'd0, (guard < 3000)}, 32'd1);
    run = 0; lows = 0;
    for (int i = 0; i < 3000; i++) begin
      if (ReadData[16] !== 1'b1) break;
      run++;
      if (!led_b_n) lows++;
      @(negedge clk); #1;
    end
    chk("blink_off_len", run, 32'd512);
    chk("blink_off_lows", lows, 32'd0);
    run = 0; lows = 0;
    for (int i = 0; i < 3000; i++) begin
      if (ReadData[16] !== 1'b0) break;
      run++;
      if (!led_b_n) lows++;
      @(negedge clk); #1;
    end
    chk("blink_on_len", run, 32'd512);
    chk("blink_on_lows", lows, 32'd510);

    // Ignored stores: misaligned, STATUS, outside window
    store(32'h400, 32'd1);
    DataAdr = 32'h405; #1; chk("hit_misaligned", {31'd0, hit}, 32'd0);
    store(32'h405, 32'h11);
    store(32'h418, 32'hFFFF_FFFF);
    store(32'h500, 32'h22);
    store(32'h41C, 32'h33);
    rd(32'h404, v); chk("ignored_duty_r", v, 32'd200);
    rd(32'h400, v); chk("ignored_ctrl", v, 32'd1);
    rd(32'h418, v); chk("status_blink_clr", v, 32'd0);
    rd(32'h41C, v); chk("rsvd_after_wr", v, 32'd0);

    // Asynchronous reset mid-frame while blue is lit
    guard = 0;
    while (led_b_n !== 1'b0 && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    chk("b_low_before_rst", {31'd0, led_b_n}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_led_r", {31'd0, led_r_n}, 32'd1);
    chk("async_led_b", {31'd0, led_b_n}, 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rd(32'h400, v); chk("post_rst_ctrl", v, 32'd0);
    rd(32'h404, v); chk("post_rst_duty_r", v, 32'd0);
    rd(32'h40C, v); chk("post_rst_duty_b", v, 32'd0);
    rd(32'h410, v); chk("post_rst_prescale", v, 32'd46);
    rd(32'h414, v); chk("post_rst_blink", v, 32'd0);
    rd(32'h418, v); chk("post_rst_status", v, 32'd0);
    chk("post_rst_led_b", {31'd0, led_b_n}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
